univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits, SHALL be >= 2.
REQ-002 Parameter CNT_W, default 4, burst-count width in bits, SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  step enable; when low, register and burst progress SHALL stall.
REQ-006 mode  input  3  operation select; encoding is given in REQ-011.
REQ-007 ser_in_l  input  1  serial bit entering the MSB on right shifts.
REQ-008 ser_in_r  input  1  serial bit entering the LSB on left shifts.
REQ-009 par_in  input  WIDTH  parallel load data.
REQ-010 start / shift_cnt  input  1 / CNT_W  burst request and burst step count; q output WIDTH register; ser_out_l = q[WIDTH-1] and ser_out_r = q[0] combinational; busy output 1; done output 1.

Function
REQ-011 Mode encoding SHALL be:
- 000 HOLD
- 001 SHL: shift left, ser_in_r into bit 0
- 010 SHR: shift right, ser_in_l into MSB
- 011 ROL
- 100 ROR
- 101 ASR: MSB replicated
- 110 LOAD: q <= par_in
- 111 CLEAR: q <= 0
REQ-012 Single-step: in IDLE with en=1 and start=0, the selected mode SHALL be applied once at the edge; q is visible the following cycle.
REQ-013 FSM states SHALL be IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE, for exactly one cycle.
REQ-014 IDLE -> RUN: at an edge with start=1, en=1 and mode in 001..101, mode and shift_cnt SHALL be latched; q is not modified at that edge.
REQ-015 start in IDLE with mode HOLD, LOAD or CLEAR SHALL be treated as a single step per REQ-012, with no burst and no done.
REQ-016 In RUN, each edge with en=1 SHALL apply the latched mode once and decrement the remaining count.
- Remaining==1 at that edge: transition to DONE.
- en=0: no shift, no decrement.
REQ-017 shift_cnt=0 at start SHALL go IDLE -> DONE directly with q unchanged; DONE -> IDLE always occurs on the next edge.
REQ-018 start, mode, par_in and the serial inputs SHALL be ignored during RUN and DONE, except that the serial inputs feed SHL/SHR steps in RUN.
REQ-019 Any shift_cnt up to 2^CNT_W-1 SHALL be legal; a rotate by a multiple of WIDTH SHALL return the original q.

Reset
REQ-020 rst=1 at an edge SHALL set q=0, state=IDLE, busy=0, done=0, remaining=0, and SHALL take priority over en and start.
REQ-021 A reset during RUN or DONE SHALL abort the burst; done SHALL NOT assert for the aborted burst.

Structure
REQ-022 Package univ_shift_pkg SHALL hold the mode enum (3-bit) and the FSM state enum.
REQ-023 Sub-module usr_next_val (purely combinational: q, mode, ser_in_l, ser_in_r, par_in -> next q) SHALL be shared by the single-step and burst paths.

Verification (WIDTH=8, CNT_W=4)
REQ-024 LOAD par_in=8'hA5, then SHL with ser_in_r=1 -> q=8'h4B, ser_out_l=0, ser_out_r=1.
REQ-025 LOAD 8'h90, then ASR -> q=8'hC8; LOAD 8'h01, then ROR -> q=8'h80.
REQ-026 LOAD 8'h01, then start with ROL and shift_cnt=3 -> busy high for 3 cycles, q=8'h08, done high for 1 cycle, then IDLE.
REQ-027 Same burst with en=0 for 2 cycles mid-RUN -> q frozen during the stall, busy high for 5 cycles total, final q=8'h08; a start pulse during RUN is ignored.
REQ-028 start with shift_cnt=0 -> done high on the next cycle, busy never high, q unchanged; ROL burst with shift_cnt=8 on 8'h3C -> q=8'h3C.
REQ-029 rst asserted in the 2nd RUN cycle of a shift_cnt=5 burst -> next cycle q=0, busy=0, and done stays low.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Package shared by the universal shift register slice.
// Holds the 3-bit operation encoding, the burst FSM states and a helper
// that tells which operations may run as a multi-step burst.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ASR   = 3'b101,
    MODE_LOAD  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the five shift/rotate operations make sense repeated as a burst;
  // HOLD, LOAD and CLEAR with start raised degrade to a single step.
  function automatic logic is_burst_mode(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg.
// master: drives en, mode, serial inputs, par_in, start, shift_cnt and
//         observes q, serial outputs, busy and done.
// slave : the register itself (the mirror image of master).
interface univ_shift_reg_if
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             en;
  mode_e            mode;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, ser_in_l, ser_in_r, par_in, start, shift_cnt,
    input  q, ser_out_l, ser_out_r, busy, done
  );

  modport slave (
    input  en, mode, ser_in_l, ser_in_r, par_in, start, shift_cnt,
    output q, ser_out_l, ser_out_r, busy, done
  );

endinterface

// File: rtl/usr_next_val.sv
// Purely combinational next-value function of the shift register.
// Ports: q (current value), mode (operation), ser_in_l (bit entering the
// MSB on right shifts), ser_in_r (bit entering the LSB on left shifts),
// par_in (load data) -> next_q (value after one application of mode).
module usr_next_val
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    case (mode)
      MODE_HOLD:  next_q = q;
      MODE_SHL:   next_q = {q[WIDTH-2:0], ser_in_r};
      MODE_SHR:   next_q = {ser_in_l, q[WIDTH-1:1]};
      MODE_ROL:   next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:   next_q = {q[0], q[WIDTH-1:1]};
      MODE_ASR:   next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_LOAD:  next_q = par_in;
      MODE_CLEAR: next_q = '0;
      default:    next_q = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and counted-burst operation.
// Ports: clk (rising-edge clock), rst (synchronous active-high reset),
// bus (univ_shift_reg_if.slave): en stalls everything when low; mode picks
// the operation; start + shift_cnt request a burst of shift/rotate steps;
// q is the register, ser_out_l/ser_out_r its MSB/LSB; busy is high while a
// burst runs and done pulses for one cycle when a burst completes.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  univ_shift_reg_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  mode_e            mode_lat_q, mode_lat_d;
  logic [WIDTH-1:0] q_q, q_d;

  mode_e            sel_mode;
  logic [WIDTH-1:0] next_q;

  // During a burst the latched mode drives the datapath so that mode
  // changes on the bus cannot disturb it; otherwise the live mode is used.
  assign sel_mode = (state_q == ST_RUN) ? mode_lat_q : bus.mode;

  usr_next_val #(
    .WIDTH (WIDTH)
  ) u_next_val (
    .q        (q_q),
    .mode     (sel_mode),
    .ser_in_l (bus.ser_in_l),
    .ser_in_r (bus.ser_in_r),
    .par_in   (bus.par_in),
    .next_q   (next_q)
  );

  // Next-state logic. In IDLE a burst start only latches mode and count;
  // q is not touched on that edge. A zero count skips RUN entirely.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    mode_lat_d = mode_lat_q;
    q_d        = q_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          if (bus.start && is_burst_mode(bus.mode)) begin
            mode_lat_d = bus.mode;
            rem_d      = bus.shift_cnt;
            state_d    = (bus.shift_cnt == '0) ? ST_DONE : ST_RUN;
          end else begin
            q_d = next_q;
          end
        end
      end
      ST_RUN: begin
        if (bus.en) begin
          q_d   = next_q;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rem_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset wins over everything and aborts a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      mode_lat_q <= MODE_HOLD;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      mode_lat_q <= mode_lat_d;
      q_q        <= q_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.ser_out_l = q_q[WIDTH-1];
  assign bus.ser_out_r = q_q[0];
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

  univ_shift_reg #(
    .WIDTH (8),
    .CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive every bus input in one go.
  task automatic applyStimulus(input logic e, input mode_e m, input logic s,
                               input logic [3:0] cnt, input logic [7:0] par,
                               input logic sl, input logic sr);
    bus.en        = e;
    bus.mode      = m;
    bus.start     = s;
    bus.shift_cnt = cnt;
    bus.par_in    = par;
    bus.ser_in_l  = sl;
    bus.ser_in_r  = sr;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run a burst already requested on the bus until done, counting busy
  // cycles; start is dropped after the launching edge.
  task automatic runBurst(input int max_cycles, output int busy_cycles,
                          output logic timed_out);
    busy_cycles = 0;
    timed_out   = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.busy) busy_cycles++;
      tick();
      bus.start = 1'b0;
      if (bus.done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   busy_cycles;
    logic timed_out;
    total = 0;
    bad   = 0;

    // Reset has priority over an active load request.
    rst = 1'b1;
    applyStimulus(1'b1, MODE_LOAD, 1'b1, 4'd0, 8'hA5, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_q", bus.q, 8'h00);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_done", bus.done, 1'b0);
    rst = 1'b0;

    // Single steps.
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    tick();
    checkOutput("load_a5", bus.q, 8'hA5);
    applyStimulus(1'b1, MODE_SHL, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("shl_q", bus.q, 8'h4B);
    checkOutput("shl_ser_out_l", bus.ser_out_l, 1'b0);
    checkOutput("shl_ser_out_r", bus.ser_out_r, 1'b1);
    applyStimulus(1'b0, MODE_SHL, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("en_low_stall", bus.q, 8'h4B);

    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'h90, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ASR, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("asr_q", bus.q, 8'hC8);
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ROR, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("ror_q", bus.q, 8'h80);
    applyStimulus(1'b1, MODE_SHR, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("shr_q", bus.q, 8'hC0);
    applyStimulus(1'b1, MODE_ROL, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("rol_q", bus.q, 8'h81);
    applyStimulus(1'b1, MODE_CLEAR, 1'b0, 4'd0, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("clear_q", bus.q, 8'h00);

    // start with LOAD is just a single step.
    applyStimulus(1'b1, MODE_LOAD, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0);
    tick();
    checkOutput("start_load_q", bus.q, 8'h5A);
    checkOutput("start_load_busy", bus.busy, 1'b0);
    applyStimulus(1'b1, MODE_HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("start_load_done", bus.done, 1'b0);
    checkOutput("hold_q", bus.q, 8'h5A);

    // ROL burst of 3 on 8'h01.
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ROL, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
    runBurst(20, busy_cycles, timed_out);
    checkOutput("burst3_timeout", timed_out, 1'b0);
    checkOutput("burst3_busy_cycles", busy_cycles, 3);
    checkOutput("burst3_q", bus.q, 8'h08);
    checkOutput("burst3_busy_in_done", bus.busy, 1'b0);
    tick();
    checkOutput("burst3_done_one_cycle", bus.done, 1'b0);
    checkOutput("burst3_idle_busy", bus.busy, 1'b0);

    // Same burst with a two-cycle stall and a stray start/load mid-run.
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'h01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ROL, 1'b1, 4'd3, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("stall_launch_q", bus.q, 8'h01);
    checkOutput("stall_launch_busy", bus.busy, 1'b1);
    applyStimulus(1'b1, MODE_HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("stall_step1_q", bus.q, 8'h02);
    applyStimulus(1'b0, MODE_HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("stall_frozen1_q", bus.q, 8'h02);
    checkOutput("stall_frozen1_busy", bus.busy, 1'b1);
    applyStimulus(1'b0, MODE_LOAD, 1'b1, 4'd9, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("stall_frozen2_q", bus.q, 8'h02);
    applyStimulus(1'b1, MODE_LOAD, 1'b1, 4'd9, 8'hFF, 1'b0, 1'b0);
    tick();
    checkOutput("stall_step2_q", bus.q, 8'h04);
    checkOutput("stall_step2_busy", bus.busy, 1'b1);
    applyStimulus(1'b1, MODE_HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("stall_final_q", bus.q, 8'h08);
    checkOutput("stall_final_done", bus.done, 1'b1);
    tick();
    checkOutput("stall_back_idle", bus.done, 1'b0);

    // Zero-count burst goes straight to DONE.
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'h77, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ROL, 1'b1, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("zero_cnt_done", bus.done, 1'b1);
    checkOutput("zero_cnt_busy", bus.busy, 1'b0);
    checkOutput("zero_cnt_q", bus.q, 8'h77);
    applyStimulus(1'b1, MODE_HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("zero_cnt_done_clear", bus.done, 1'b0);

    // Rotate by WIDTH returns the original value.
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ROL, 1'b1, 4'd8, 8'h00, 1'b0, 1'b0);
    runBurst(30, busy_cycles, timed_out);
    checkOutput("rol8_timeout", timed_out, 1'b0);
    checkOutput("rol8_busy_cycles", busy_cycles, 8);
    checkOutput("rol8_q", bus.q, 8'h3C);
    applyStimulus(1'b1, MODE_HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    tick();

    // Reset in the second RUN cycle of a 5-step SHL burst aborts it.
    applyStimulus(1'b1, MODE_LOAD, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_SHL, 1'b1, 4'd5, 8'h00, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    checkOutput("abort_pre_q", bus.q, 8'h4A);
    checkOutput("abort_pre_busy", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_q", bus.q, 8'h00);
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_done", bus.done, 1'b0);
    applyStimulus(1'b1, MODE_HOLD, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("abort_done_stays_low", bus.done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
